// File: rtl/block_memory_if.sv
// block_memory_if: request/response bus between a block requester (cache)
// and the block_memory model.
//   req_valid/req_ready  request handshake (ready only while memory is idle)
//   req_write            1 = block write, 0 = block read
//   req_addr             word address; low log2(WPB) bits ignored
//   req_wdata            write block, word k at [k*DATA_W +: DATA_W]
//   resp_valid/ready     response handshake
//   resp_write           echo of the request's write flag
//   resp_rdata           read (or written) block, same packing as req_wdata
interface block_memory_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 15,
    parameter int WPB    = 4
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_write;
    logic [ADDR_W-1:0]       req_addr;
    logic [DATA_W*WPB-1:0]   req_wdata;
    logic                    resp_valid;
    logic                    resp_ready;
    logic                    resp_write;
    logic [DATA_W*WPB-1:0]   resp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_write, resp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_write, resp_rdata
    );
endinterface

// File: rtl/block_memory.sv
// block_memory: main-memory model serving block reads/writes for the cache.
// After reset it sweeps INIT_VAL into words [INIT_LO, INIT_HI], then accepts
// one request at a time: LATENCY wait cycles, WPB single-word transfer
// cycles, then holds the response until resp_ready.
// Ports:
//   clk, rst     clock (rising edge), asynchronous active-high reset
//   bus          block_memory_if slave side (request/response handshake)
//   init_done    high once the init sweep has completed
//   dbg_en       debug read enable
//   dbg_addr     debug word address
//   dbg_data     mem[dbg_addr] when dbg_en, else 0 (combinational)
module block_memory #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 15,
    parameter int WPB      = 4,
    parameter int LATENCY  = 4,
    parameter int INIT_LO  = 1024,
    parameter int INIT_HI  = 8192,
    parameter int INIT_VAL = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    block_memory_if.slave        bus,
    output logic                 init_done,
    input  logic                 dbg_en,
    input  logic [ADDR_W-1:0]    dbg_addr,
    output logic [DATA_W-1:0]    dbg_data
);
    localparam int LOG_WPB = (WPB > 1) ? $clog2(WPB) : 0;
    localparam int KW      = (LOG_WPB > 0) ? LOG_WPB : 1;
    localparam int CW      = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_WAIT, S_XFER, S_RESP} state_t;

    state_t                     state, state_n;
    logic [ADDR_W-1:0]          ptr;
    logic [ADDR_W-1:0]          base;
    logic [ADDR_W-1:0]          xaddr;
    logic [KW-1:0]              k;
    logic [CW-1:0]              cnt;
    logic                       wr_q;
    logic [WPB-1:0][DATA_W-1:0] wdata_q;
    logic [WPB-1:0][DATA_W-1:0] rdata_q;
    logic                       accept;
    logic                       last_k;
    logic                       lat_done;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // base has its low bits cleared, so OR-ing in k never carries out of
    // the block and the address cannot wrap.
    assign xaddr    = base | ADDR_W'(k);
    assign last_k   = (k == KW'(WPB - 1));
    assign lat_done = (cnt == CW'(LATENCY - 1));

    always_comb begin
        state_n        = state;
        accept         = 1'b0;
        bus.req_ready  = (state == S_IDLE);
        bus.resp_valid = (state == S_RESP);
        bus.resp_write = wr_q;
        bus.resp_rdata = rdata_q;
        init_done      = (state != S_INIT);
        case (state)
            S_INIT: if (ptr == ADDR_W'(INIT_HI)) state_n = S_IDLE;
            S_IDLE: begin
                if (bus.req_valid) begin
                    accept  = 1'b1;
                    state_n = (LATENCY > 0) ? S_WAIT : S_XFER;
                end
            end
            S_WAIT: if (lat_done) state_n = S_XFER;
            S_XFER: if (last_k) state_n = S_RESP;
            S_RESP: if (bus.resp_ready) state_n = S_IDLE;
            default: state_n = S_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_INIT;
            ptr     <= ADDR_W'(INIT_LO);
            base    <= '0;
            k       <= '0;
            cnt     <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_n;
            if (state == S_INIT) ptr <= ptr + 1'b1;
            if (accept) begin
                base    <= bus.req_addr & ~ADDR_W'(WPB - 1);
                wr_q    <= bus.req_write;
                wdata_q <= bus.req_wdata;
                cnt     <= '0;
                k       <= '0;
            end
            if (state == S_WAIT) cnt <= cnt + 1'b1;
            if (state == S_XFER) begin
                // a write reflects its own data back in the response block
                rdata_q[k] <= wr_q ? wdata_q[k] : mem[xaddr];
                k          <= k + 1'b1;
            end
        end
    end

    // Array is not reset; writes are suppressed while rst is held.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == S_INIT)
                mem[ptr] <= DATA_W'(INIT_VAL);
            else if (state == S_XFER && wr_q)
                mem[xaddr] <= wdata_q[k];
        end
    end

    assign dbg_data = dbg_en ? mem[dbg_addr] : '0;
endmodule

// File: tb/tb_block_memory.sv
module tb_block_memory;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         t_valid = 1'b0, t_write = 1'b0, t_resp_ready = 1'b0;
    logic [14:0]  t_addr = '0;
    logic [255:0] t_wdata = '0;
    logic         dbg_en = 1'b0;
    logic [14:0]  dbg_addr = '0;
    int           cur = 0;
    int           n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    block_memory_if #(.DATA_W(32), .ADDR_W(15), .WPB(4)) if0 ();
    block_memory_if #(.DATA_W(32), .ADDR_W(15), .WPB(1)) if1 ();
    block_memory_if #(.DATA_W(32), .ADDR_W(15), .WPB(8)) if2 ();

    assign if0.req_valid  = t_valid && cur == 0;
    assign if1.req_valid  = t_valid && cur == 1;
    assign if2.req_valid  = t_valid && cur == 2;
    assign if0.req_write  = t_write;
    assign if1.req_write  = t_write;
    assign if2.req_write  = t_write;
    assign if0.req_addr   = t_addr;
    assign if1.req_addr   = t_addr;
    assign if2.req_addr   = t_addr;
    assign if0.req_wdata  = t_wdata[127:0];
    assign if1.req_wdata  = t_wdata[31:0];
    assign if2.req_wdata  = t_wdata;
    assign if0.resp_ready = t_resp_ready && cur == 0;
    assign if1.resp_ready = t_resp_ready && cur == 1;
    assign if2.resp_ready = t_resp_ready && cur == 2;

    logic        init0, init1, init2;
    logic [31:0] dbg0, dbg1, dbg2;

    block_memory #(.WPB(4), .LATENCY(4)) dut0 (.clk(clk), .rst(rst), .bus(if0),
        .init_done(init0), .dbg_en(dbg_en), .dbg_addr(dbg_addr), .dbg_data(dbg0));
    block_memory #(.WPB(1), .LATENCY(0)) dut1 (.clk(clk), .rst(rst), .bus(if1),
        .init_done(init1), .dbg_en(dbg_en), .dbg_addr(dbg_addr), .dbg_data(dbg1));
    block_memory #(.WPB(8), .LATENCY(0)) dut2 (.clk(clk), .rst(rst), .bus(if2),
        .init_done(init2), .dbg_en(dbg_en), .dbg_addr(dbg_addr), .dbg_data(dbg2));

    // selected-DUT view of the response side
    logic         m_req_ready, m_resp_valid, m_resp_write;
    logic [255:0] m_rdata;
    always_comb begin
        m_req_ready  = if0.req_ready;
        m_resp_valid = if0.resp_valid;
        m_resp_write = if0.resp_write;
        m_rdata      = {128'd0, if0.resp_rdata};
        if (cur == 1) begin
            m_req_ready  = if1.req_ready;
            m_resp_valid = if1.resp_valid;
            m_resp_write = if1.resp_write;
            m_rdata      = {224'd0, if1.resp_rdata};
        end else if (cur == 2) begin
            m_req_ready  = if2.req_ready;
            m_resp_valid = if2.resp_valid;
            m_resp_write = if2.resp_write;
            m_rdata      = if2.resp_rdata;
        end
    end

    typedef struct {
        int           sel;
        logic         wr;
        logic [14:0]  addr;
        logic [255:0] wdata;
        logic [255:0] exp;
        int           lat;
    } vec_t;
    vec_t vecs[12];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_init(input string name);
        int  n = 0;
        logic rr_bad = 1'b0;
        while (n < 8000) begin
            @(negedge clk);
            n++;
            if (init0) break;
            if (if0.req_ready || if1.req_ready || if2.req_ready) rr_bad = 1'b1;
        end
        chk({name, "_cycles"}, 256'(n), 256'd7169);
        chk({name, "_ready_low"}, {255'd0, rr_bad}, 256'd0);
        chk({name, "_all_done"}, {254'd0, init1, init2}, 256'd3);
    endtask

    task automatic run_txn(input int sel, input logic wr, input logic [14:0] addr,
                           input logic [255:0] wd, output logic [255:0] rd,
                           output int lat, output logic rw, output logic rdy);
        cur = sel;
        @(negedge clk);
        rdy     = m_req_ready;
        t_valid = 1'b1; t_write = wr; t_addr = addr; t_wdata = wd;
        @(negedge clk);
        t_valid = 1'b0;
        lat = 0;
        while (!m_resp_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        rd = m_rdata;
        rw = m_resp_write;
        t_resp_ready = 1'b1;
        @(negedge clk);
        t_resp_ready = 1'b0;
    endtask

    task automatic dbg_rd(input logic [14:0] a, output logic [31:0] d0);
        dbg_en = 1'b1; dbg_addr = a;
        #1 d0 = dbg0;
    endtask

    localparam logic [255:0] ONES4 = {128'd0, {4{32'd1}}};
    localparam logic [255:0] ONES8 = {8{32'd1}};
    localparam logic [255:0] WB    = {128'd0, 32'h44, 32'h33, 32'h22, 32'h11};
    localparam logic [255:0] AB    = {128'd0, 32'hA3, 32'hA2, 32'hA1, 32'hA0};
    localparam logic [255:0] BB    = {128'd0, 32'hB3, 32'hB2, 32'hB1, 32'hB0};
    localparam logic [255:0] W8    = {32'h8, 32'h7, 32'h6, 32'h5, 32'h4, 32'h3, 32'h2, 32'h1};

    initial begin
        logic [255:0] rd, snap;
        logic [31:0]  d;
        int           lat;
        logic         rw, rdy, bp_bad;

        vecs[0]  = '{0, 1'b0, 15'h0406, '0,      ONES4,      8};
        vecs[1]  = '{0, 1'b1, 15'h7FFD, WB,      WB,         8};
        vecs[2]  = '{0, 1'b0, 15'h7FFF, '0,      WB,         8};
        vecs[3]  = '{0, 1'b0, 15'h1FFE, '0,      ONES4,      8};
        vecs[4]  = '{0, 1'b1, 15'h0002, AB,      AB,         8};
        vecs[5]  = '{0, 1'b0, 15'h0001, '0,      AB,         8};
        vecs[6]  = '{1, 1'b0, 15'h0400, '0,      256'd1,     1};
        vecs[7]  = '{1, 1'b1, 15'h0005, 256'h55, 256'h55,    1};
        vecs[8]  = '{1, 1'b0, 15'h0005, '0,      256'h55,    1};
        vecs[9]  = '{2, 1'b0, 15'h0403, '0,      ONES8,      8};
        vecs[10] = '{2, 1'b1, 15'h0009, W8,      W8,         8};
        vecs[11] = '{2, 1'b0, 15'h000F, '0,      W8,         8};

        // reset state
        #1;
        chk("rst_outputs", {251'd0, if0.req_ready, if0.resp_valid, if0.resp_write, init0, 1'b0}, 256'd0);
        chk("rst_rdata", {128'd0, if0.resp_rdata}, 256'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_init("init");

        dbg_rd(15'd1024, d); chk("dbg_1024", 256'(d), 256'd1);
        dbg_rd(15'd5000, d); chk("dbg_5000", 256'(d), 256'd1);
        dbg_rd(15'd8192, d); chk("dbg_8192", 256'(d), 256'd1);
        dbg_rd(15'd1023, d);
        n_cmp++;
        if (d === 32'd1) begin
            n_bad++;
            $display("FAIL dbg_1023: got %0h expected not 1", d);
        end

        for (int i = 0; i < 12; i++) begin
            run_txn(vecs[i].sel, vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, lat, rw, rdy);
            chk($sformatf("v%0d_ready", i), {255'd0, rdy}, 256'd1);
            chk($sformatf("v%0d_lat", i), 256'(lat), 256'(vecs[i].lat));
            chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp);
            chk($sformatf("v%0d_rw", i), {255'd0, rw}, {255'd0, vecs[i].wr});
        end

        dbg_rd(15'h7FFC, d); chk("dbg_7ffc", 256'(d), 256'h11);
        dbg_rd(15'h7FFF, d); chk("dbg_7fff", 256'(d), 256'h44);
        dbg_en = 1'b0;
        #1 chk("dbg_off", 256'(dbg0), 256'd0);

        // backpressure: hold response 10 cycles with a competing request
        cur = 0;
        @(negedge clk);
        t_valid = 1'b1; t_write = 1'b0; t_addr = 15'h7FFC;
        @(negedge clk);
        t_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("bp_valid", {255'd0, m_resp_valid}, 256'd1);
        snap = m_rdata;
        chk("bp_data", snap, WB);
        t_valid = 1'b1; t_addr = 15'h0404;
        bp_bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!m_resp_valid || m_rdata !== snap || m_req_ready) bp_bad = 1'b1;
        end
        chk("bp_stable", {255'd0, bp_bad}, 256'd0);
        t_resp_ready = 1'b1;
        @(negedge clk);
        t_resp_ready = 1'b0;
        chk("bp_release", {254'd0, m_req_ready, m_resp_valid}, 256'd2);
        chk("bp_hold_rdata", m_rdata, snap);
        @(negedge clk);
        t_valid = 1'b0;
        chk("bp_accepted", {255'd0, m_req_ready}, 256'd0);
        lat = 0;
        while (!m_resp_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        chk("bp2_lat", 256'(lat), 256'd8);
        chk("bp2_rdata", m_rdata, ONES4);
        t_resp_ready = 1'b1;
        @(negedge clk);
        t_resp_ready = 1'b0;

        // reset after two transfer edges of a write to block 0
        @(negedge clk);
        t_valid = 1'b1; t_write = 1'b1; t_addr = 15'h0000; t_wdata = BB;
        @(negedge clk);
        t_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_state", {253'd0, if0.resp_valid, init0, if0.req_ready}, 256'd0);
        dbg_rd(15'd0, d); chk("mid_w0", 256'(d), 256'hB0);
        dbg_rd(15'd1, d); chk("mid_w1", 256'(d), 256'hB1);
        dbg_rd(15'd2, d); chk("mid_w2", 256'(d), 256'hA2);
        dbg_rd(15'd3, d); chk("mid_w3", 256'(d), 256'hA3);
        dbg_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        wait_init("reinit");
        chk("reinit_no_resp", {255'd0, if0.resp_valid}, 256'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/block_memory.md
Name: block_memory

Overview:
- Parametrised main-memory model serving cache line fills and write-backs for the direct-mapped cache.
- Replaces the fixed 4-word, zero-latency memory with a req/resp handshake, configurable line size and access latency, block writes, and a swept power-on init.
- Also provides a combinational single-word debug read port for the bench.

Parameters:
- DATA_W, 32, bits per memory word
- ADDR_W, 15, word-address width; depth = 2^ADDR_W words
- WPB, 4, words per block, power of two >= 1; LOG_WPB = log2(WPB)
- LATENCY, 4, wait cycles between request acceptance and the first word transfer; 0 is legal
- INIT_LO, 1024, first word address initialised after reset
- INIT_HI, 8192, last word address initialised after reset (inclusive); requires INIT_LO <= INIT_HI < 2^ADDR_W
- INIT_VAL, 1, value written to every word in [INIT_LO, INIT_HI]

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_write  in  1  1 = block write, 0 = block read
- req_addr  in  ADDR_W  any word address inside the block; low LOG_WPB bits ignored
- req_wdata  in  DATA_W*WPB  write block; word k is at bits [k*DATA_W +: DATA_W]
- resp_valid  out  1  response available
- resp_ready  in  1  consumer accepts response
- resp_write  out  1  echo of the captured req_write
- resp_rdata  out  DATA_W*WPB  read block, same word packing as req_wdata
- init_done  out  1  high once the init sweep has completed
- dbg_en  in  1  debug read enable
- dbg_addr  in  ADDR_W  debug word address
- dbg_data  out  DATA_W  mem[dbg_addr] when dbg_en, else 0 (combinational)

Behaviour:
- FSM states: INIT, IDLE, WAIT, XFER, RESP.
- Reset (async) forces:
  - state = INIT, sweep pointer = INIT_LO;
  - req_ready = 0, resp_valid = 0, resp_write = 0, resp_rdata = 0, init_done = 0;
  - all counters cleared.
- The memory array itself is never reset.
- INIT: one word per clock, mem[ptr] <= INIT_VAL, ptr increments. The edge that writes INIT_HI moves to IDLE and sets init_done = 1.
  - Sweep takes INIT_HI-INIT_LO+1 cycles: 7169 with defaults.
  - Words outside the init range retain their prior contents; they are X on first power-up.
- IDLE: req_ready = 1. On an edge with req_valid = 1:
  - capture base = {req_addr[ADDR_W-1:LOG_WPB], LOG_WPB zeros}, req_write, and req_wdata;
  - go to WAIT if LATENCY > 0, else go to XFER.
- WAIT: count LATENCY edges, then go to XFER.
- XFER: word index k runs 0..WPB-1, one word per edge.
  - Read: resp_rdata word k <= mem[base+k].
  - Write: mem[base+k] <= captured wdata word k, and resp_rdata word k <= the same value.
  - The edge handling k = WPB-1 moves to RESP.
- RESP: resp_valid = 1, with resp_rdata and resp_write stable.
  - The edge with resp_ready = 1 clears resp_valid and goes to IDLE.
  - req_ready rises in the following cycle, so there are no back-to-back acceptances.
- Latency: acceptance edge E0 -> resp_valid high after edge E0+LATENCY+WPB. With defaults this is 8 edges.
- Base address arithmetic: base+k never crosses the block, so the address cannot wrap past 2^ADDR_W-1.
  - Example: addr 0x7FFF with WPB = 4 gives words 0x7FFC..0x7FFF.
- resp_rdata holds its value after the handshake until the next XFER overwrites it.
- dbg port reads the array combinationally.
  - During a write XFER it shows the pre-write value in the cycle of the write.
  - Valid in every state, including INIT.
- Reset mid-operation: the transfer is abandoned and the response is lost.
  - Words already written by a partial XFER remain committed.
  - The init sweep restarts from INIT_LO.
- req_valid during INIT/WAIT/XFER/RESP is ignored (req_ready = 0). No request is queued.

Test Plan:
- Reset and init: pulse rst, run until init_done.
  - init_done rises exactly 7169 cycles after reset release.
  - dbg reads give 1 at addresses 1024, 5000 and 8192; address 1023 is not equal to 1.
  - req_ready = 0 throughout INIT.
- Block read timing: read at req_addr 0x0406.
  - resp_valid rises 8 edges after acceptance.
  - resp_rdata = {32'd1, 32'd1, 32'd1, 32'd1}, covering words 0x404..0x407.
  - resp_write = 0.
- Block write then readback: write req_addr 0x7FFD, wdata words {A, B, C, D} = 0x11, 0x22, 0x33, 0x44.
  - dbg reads 0x7FFC = 0x11 and 0x7FFF = 0x44.
  - A following read returns the same 128-bit block; no address wrap occurs.
- Response backpressure: hold resp_ready = 0 for 10 cycles in RESP.
  - resp_valid and resp_rdata stay stable.
  - A req_valid asserted during this window is not accepted.
  - Acceptance happens the cycle after resp_ready pulses.
- Parameter sweep: LATENCY = 0, WPB = 1 and WPB = 8.
  - Latency is 1 edge and 8 edges respectively.
  - Packing is correct, e.g. a WPB = 8 read of base 0x400 returns eight 1s.
- Reset mid-write: assert rst after 2 XFER edges of a 4-word write to 0x0000.
  - Words 0 and 1 are updated; words 2 and 3 are unchanged.
  - resp_valid stays 0 and the FSM re-enters INIT.
